// File: rtl/ring_buffer_dma_sched_if.sv
// DMA output stream: one flit per valid/ready handshake, tagged with block
// boundaries and the index of the ring buffer it came from.
interface ring_buffer_dma_sched_if #(
  parameter int QW = 2,
  parameter int DW = 512
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [QW-1:0] out_qid;

  modport master (output out_valid, out_data, out_sop, out_eop, out_qid, input out_ready);
  modport slave  (input out_valid, out_data, out_sop, out_eop, out_qid, output out_ready);
endinterface

// File: rtl/ring_buffer_dma_sched.sv
// Round-robin DMA scheduler: grants one ring buffer at a time, reads its block
// through the 2-cycle BRAM port and streams it out through a credit-guarded skid FIFO.
//
//   state | meaning
//   IDLE  | no burst; pick next pending buffer at/after rr pointer
//   READ  | issuing reads while FIFO + in-flight reads leave room
//   DRAIN | all reads issued; waiting for the eop flit to leave
//   DONE  | one-cycle done pulse to the granted buffer, advance rr
module ring_buffer_dma_sched #(
  parameter int NUM_RB     = 4,
  parameter int PDU_DEPTH  = 512,
  parameter int PDU_AWIDTH = $clog2(PDU_DEPTH),
  parameter int SKID_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RB-1:0]            rb_dma_start,
  input  logic [NUM_RB*PDU_AWIDTH-1:0] rb_dma_size,
  input  logic [NUM_RB*PDU_AWIDTH-1:0] rb_dma_base_addr,
  output logic [NUM_RB-1:0]            rb_dma_done,
  output logic [PDU_AWIDTH-1:0]        rb_rd_addr,
  output logic [NUM_RB-1:0]            rb_rd_en,
  input  logic [NUM_RB-1:0]            rb_rd_valid,
  input  logic [NUM_RB*512-1:0]        rb_rd_data,
  ring_buffer_dma_sched_if.master      dma,
  output logic                         busy
);
  localparam int AW = PDU_AWIDTH;
  localparam int DW = 512;
  localparam int QW = (NUM_RB > 1) ? $clog2(NUM_RB) : 1;
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [CW:0]   SKID_LIM = (CW+1)'(SKID_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(SKID_DEPTH - 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(NUM_RB - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NUM_RB-1:0] pending_q, pending_d;
  logic [AW-1:0]     base_q [NUM_RB];
  logic [AW-1:0]     base_d [NUM_RB];
  logic [AW-1:0]     size_q [NUM_RB];
  logic [AW-1:0]     size_d [NUM_RB];
  logic [QW-1:0]     rr_q, rr_d, qsel_q, qsel_d;
  logic [AW-1:0]     addr_q, addr_d, rem_q, rem_d;
  logic              first_q, first_d;
  logic [1:0]        t1_q, t1_d, t2_q, t2_d;   // {sop, eop} of reads in flight
  logic [CW-1:0]     inflight_q, inflight_d, cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW+1:0]     fifo_mem_q [SKID_DEPTH];

  logic              issue, push, pop, nempty, gnt_found;
  logic [QW-1:0]     gnt_idx, idx;
  logic [DW+1:0]     head;
  logic [DW-1:0]     sel_data;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_RB; k++) begin
      idx = QW'((int'(rr_q) + k) % NUM_RB);
      if (!gnt_found && pending_q[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end

    // Credit rule: FIFO entries plus reads still in the BRAM pipe never exceed the FIFO depth.
    issue    = (state_q == READ) && (({1'b0, cnt_q} + {1'b0, inflight_q}) < SKID_LIM);
    push     = rb_rd_valid[qsel_q] && (inflight_q != '0);
    nempty   = (cnt_q != '0);
    pop      = nempty && dma.out_ready;
    head     = fifo_mem_q[rd_ptr_q];
    sel_data = rb_rd_data[qsel_q*DW +: DW];

    for (int i = 0; i < NUM_RB; i++) begin
      pending_d[i]   = rb_dma_start[i] |
                       (pending_q[i] & ~((state_q == IDLE) && gnt_found && (gnt_idx == QW'(i))));
      base_d[i]      = rb_dma_start[i] ? rb_dma_base_addr[i*AW +: AW] : base_q[i];
      size_d[i]      = rb_dma_start[i] ? rb_dma_size[i*AW +: AW] : size_q[i];
      rb_rd_en[i]    = issue && (qsel_q == QW'(i));
      rb_dma_done[i] = (state_q == DONE) && (qsel_q == QW'(i));
    end

    state_d = state_q;
    qsel_d  = qsel_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    first_d = first_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: if (gnt_found) begin
        qsel_d  = gnt_idx;
        addr_d  = base_q[gnt_idx];
        rem_d   = size_q[gnt_idx];
        first_d = 1'b1;
        state_d = (size_q[gnt_idx] == '0) ? DONE : READ;
      end
      READ: if (issue) begin
        addr_d  = addr_q + AW'(1);
        rem_d   = rem_q - AW'(1);
        first_d = 1'b0;
        if (rem_q == AW'(1)) state_d = DRAIN;
      end
      DRAIN: if (pop && head[0]) state_d = DONE;
      DONE: begin
        rr_d    = (qsel_q == Q_LAST) ? '0 : qsel_q + QW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    t1_d       = issue ? {first_q, rem_q == AW'(1)} : 2'b00;
    t2_d       = t1_q;
    inflight_d = inflight_q + (issue ? CW'(1) : CW'(0)) - (push ? CW'(1) : CW'(0));
    cnt_d      = cnt_q + (push ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    wr_ptr_d   = push ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;

    rb_rd_addr    = addr_q;
    busy          = (state_q != IDLE);
    dma.out_valid = nempty;
    dma.out_data  = nempty ? head[DW+1:2] : '0;
    dma.out_sop   = nempty & head[1];
    dma.out_eop   = nempty & head[0];
    dma.out_qid   = nempty ? qsel_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rr_q       <= '0;
      qsel_q     <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      t1_q       <= '0;
      t2_q       <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < NUM_RB; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      qsel_q     <= qsel_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int i = 0; i < NUM_RB; i++) begin
        base_q[i] <= base_d[i];
        size_q[i] <= size_d[i];
      end
    end
  end

  // Storage needs no reset: the output is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {sel_data, t2_q};
  end
endmodule
